// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port SRAM wrapper.
// Port 0 is read-only fetch, port 1 is the read/write LSU.
module sram_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_MAX   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_req_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    input  logic [3:0]            p1_wmask_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [3:0]            sram_wmask_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam int TL = READ_LATENCY - 1;

    // rr_q: 0 means port 0 is preferred on the next tie
    logic                    rr_q;
    logic [SW-1:0]           starve_q;
    logic [READ_LATENCY-1:0] tag_v_q;
    logic [READ_LATENCY-1:0] tag_p_q;
    logic                    win0;
    logic                    win1;
    logic                    rd_push;

    // Pick the winner; nothing is granted while reset is held
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && p1_req_i) begin
                if (starve_q == SMAX || !rr_q) begin
                    win0 = 1'b1;
                end else begin
                    win1 = 1'b1;
                end
            end else begin
                win0 = p0_req_i;
                win1 = p1_req_i;
            end
        end
    end

    assign p0_gnt_o = win0;
    assign p1_gnt_o = win1;
    assign rd_push  = win0 | (win1 & ~p1_we_i);

    // Drive the SRAM wrapper straight from the winner
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = 4'h0;
        if (win0) begin
            sram_csb_o  = 1'b0;
            sram_addr_o = p0_addr_i;
        end else if (win1) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~p1_we_i;
            sram_addr_o  = p1_addr_i;
            sram_wdata_o = p1_wdata_i;
            sram_wmask_o = p1_wmask_i;
        end
    end

    // Arbiter state and the read tag pipe that mirrors SRAM latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q     <= 1'b0;
            starve_q <= '0;
            tag_v_q  <= '0;
            tag_p_q  <= '0;
        end else begin
            if (win0 || win1) begin
                rr_q <= win0;
            end
            if (win0 || !p0_req_i) begin
                starve_q <= '0;
            end else if (win1 && starve_q != SMAX) begin
                starve_q <= starve_q + SW'(1);
            end
            tag_v_q[0] <= rd_push;
            tag_p_q[0] <= win1;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_v_q[k] <= tag_v_q[k-1];
                tag_p_q[k] <= tag_p_q[k-1];
            end
        end
    end

    assign p0_rvalid_o = tag_v_q[TL] & ~tag_p_q[TL];
    assign p1_rvalid_o = tag_v_q[TL] & tag_p_q[TL];
    assign p0_rdata_o  = sram_rdata_i;
    assign p1_rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (latency 1 and 3)
// share stimulus; a queue-based reference model predicts outputs.
module tb_sram_port_arbiter;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        r0;
        logic [11:0] a0;
        logic        r1;
        logic        we;
        logic [11:0] a1;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        eg0;
        logic        eg1;
        logic        ck;
        logic        cport;
        logic [31:0] cdat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic        p0_req;
    logic [11:0] p0_addr;
    logic        p1_req;
    logic        p1_we;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_wmask;

    logic        o_g0  [2];
    logic        o_g1  [2];
    logic        o_v0  [2];
    logic        o_v1  [2];
    logic        o_csb [2];
    logic        o_web [2];
    logic [31:0] o_d0  [2];
    logic [31:0] o_d1  [2];
    logic [31:0] o_wd  [2];
    logic [11:0] o_ad  [2];
    logic [3:0]  o_wm  [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        if (a == 12'h030) return 32'hFFFFFFFF;
        return {a, a[7:0], a} ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int SMX = (g == 0) ? 4 : 2;
        logic        g0, g1, v0, v1, csb, web;
        logic [31:0] d0, d1, wdata, rdata, cur, mrg;
        logic [11:0] addr;
        logic [3:0]  wmask;
        logic [31:0] mem  [4096];
        logic        wr   [4096];
        logic [31:0] pipe [LAT];

        sram_port_arbiter #(
            .DATA_WIDTH(32),
            .ADDR_WIDTH(12),
            .READ_LATENCY(LAT),
            .STARVE_MAX(SMX)
        ) dut (
            .clk_i(clk),
            .rst_i(rst),
            .p0_req_i(p0_req),
            .p0_addr_i(p0_addr),
            .p0_gnt_o(g0),
            .p0_rvalid_o(v0),
            .p0_rdata_o(d0),
            .p1_req_i(p1_req),
            .p1_we_i(p1_we),
            .p1_addr_i(p1_addr),
            .p1_wdata_i(p1_wdata),
            .p1_wmask_i(p1_wmask),
            .p1_gnt_o(g1),
            .p1_rvalid_o(v1),
            .p1_rdata_o(d1),
            .sram_csb_o(csb),
            .sram_web_o(web),
            .sram_addr_o(addr),
            .sram_wdata_o(wdata),
            .sram_wmask_o(wmask),
            .sram_rdata_i(rdata)
        );

        assign cur   = wr[addr] ? mem[addr] : init_val(addr);
        assign mrg   = merge(cur, wdata, wmask);
        assign rdata = pipe[LAT-1];

        // Behavioural SRAM macro with LAT-cycle read latency
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int a = 0; a < 4096; a++) wr[a] <= 1'b0;
            end else if (!csb && !web) begin
                mem[addr] <= mrg;
                wr[addr]  <= 1'b1;
            end
            pipe[0] <= (!csb && web) ? cur : 32'h0BAD0BAD;
            for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        end

        assign o_g0[g]  = g0;
        assign o_g1[g]  = g1;
        assign o_v0[g]  = v0;
        assign o_v1[g]  = v1;
        assign o_d0[g]  = d0;
        assign o_d1[g]  = d1;
        assign o_csb[g] = csb;
        assign o_web[g] = web;
        assign o_ad[g]  = addr;
        assign o_wd[g]  = wdata;
        assign o_wm[g]  = wmask;
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_rr [2];
    int          m_starve [2];
    logic [31:0] ref_mem [2][4096];
    resp_t       q0 [$];
    resp_t       q1 [$];
    logic [31:0] last_p0 [2];
    logic [31:0] last_p1 [2];
    logic        s_g0 [2];
    logic        s_g1 [2];

    task automatic chkb(input string nm, input int i,
                        input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc %0d: got %b want %b",
                     nm, i, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input int i,
                        input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc %0d: got %h want %h",
                     nm, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_rr[i] = 0;
            m_starve[i] = 0;
        end
    endtask

    // One clock: check outputs against the model, then advance
    task automatic cycle(output int w0);
        int          w;
        bit          got;
        resp_t       r;
        logic        e0, e1;
        w0 = -1;
        #1;
        for (int i = 0; i < 2; i++) begin
            w = -1;
            if (p0_req && !p1_req) w = 0;
            else if (p1_req && !p0_req) w = 1;
            else if (p0_req && p1_req)
                w = (m_starve[i] == smax(i)) ? 0 : m_rr[i];
            if (i == 0) w0 = w;
            s_g0[i] = o_g0[i];
            s_g1[i] = o_g1[i];
            chkb("p0_gnt", i, o_g0[i], w == 0);
            chkb("p1_gnt", i, o_g1[i], w == 1);
            chkb("csb", i, o_csb[i], w < 0);
            chkb("web", i, o_web[i], !(w == 1 && p1_we));
            if (w == 0) begin
                chkw("addr", i, 32'(o_ad[i]), 32'(p0_addr));
                chkw("wdata", i, o_wd[i], 32'h0);
                chkw("wmask", i, 32'(o_wm[i]), 32'h0);
            end else if (w == 1) begin
                chkw("addr", i, 32'(o_ad[i]), 32'(p1_addr));
                chkw("wdata", i, o_wd[i], p1_wdata);
                chkw("wmask", i, 32'(o_wm[i]), 32'(p1_wmask));
            end
            got = 0;
            if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin
                r = q0.pop_front();
                got = 1;
            end
            if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                got = 1;
            end
            e0 = got && r.port == 0;
            e1 = got && r.port == 1;
            chkb("p0_rvalid", i, o_v0[i], e0);
            chkb("p1_rvalid", i, o_v1[i], e1);
            if (e0) chkw("p0_rdata", i, o_d0[i], r.data);
            if (e1) chkw("p1_rdata", i, o_d1[i], r.data);
            if (o_v0[i]) last_p0[i] = o_d0[i];
            if (o_v1[i]) last_p1[i] = o_d1[i];
            if (w == 1 && p1_we) begin
                ref_mem[i][p1_addr] =
                    merge(ref_mem[i][p1_addr], p1_wdata, p1_wmask);
            end else if (w >= 0) begin
                r.due  = cyc + lat(i);
                r.port = w;
                r.data = ref_mem[i][(w == 0) ? p0_addr : p1_addr];
                if (i == 0) q0.push_back(r);
                else q1.push_back(r);
            end
            if (w == 0 || !p0_req) m_starve[i] = 0;
            else if (w == 1 && m_starve[i] < smax(i)) m_starve[i]++;
            if (w >= 0) m_rr[i] = 1 - w;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_in();
        p0_req   = 1'b0;
        p1_req   = 1'b0;
        p1_we    = 1'b0;
        p0_addr  = 12'h0;
        p1_addr  = 12'h0;
        p1_wdata = 32'h0;
        p1_wmask = 4'h0;
    endtask

    function automatic vec_t mk(input logic r0, input logic [11:0] a0,
                                input logic r1, input logic we,
                                input logic [11:0] a1,
                                input logic [31:0] wd, input logic [3:0] wm,
                                input logic eg0, input logic eg1,
                                input logic ck, input logic cport,
                                input logic [31:0] cdat);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.we = we; v.a1 = a1;
        v.wd = wd; v.wm = wm; v.eg0 = eg0; v.eg1 = eg1;
        v.ck = ck; v.cport = cport; v.cdat = cdat;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];
        int   w;
        bit   pend0, pend1;
        int   gotk [2];

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 4096; a++)
                ref_mem[i][a] = init_val(12'(a));
        for (int i = 0; i < 2; i++) begin
            last_p0[i] = 32'h0;
            last_p1[i] = 32'h0;
        end
        model_reset();

        // Reset with requests pending: everything must stay quiet
        rst = 1'b1;
        mem_clr = 1'b1;
        idle_in();
        p0_req = 1'b1;
        p1_req = 1'b1;
        p0_addr = 12'h123;
        p1_addr = 12'h456;
        #2;
        for (int i = 0; i < 2; i++) begin
            chkb("rst_g0", i, o_g0[i], 1'b0);
            chkb("rst_g1", i, o_g1[i], 1'b0);
            chkb("rst_csb", i, o_csb[i], 1'b1);
            chkb("rst_web", i, o_web[i], 1'b1);
            chkb("rst_v0", i, o_v0[i], 1'b0);
            chkb("rst_v1", i, o_v1[i], 1'b0);
            chkw("rst_addr", i, 32'(o_ad[i]), 32'h0);
            chkw("rst_wdata", i, o_wd[i], 32'h0);
            chkw("rst_wmask", i, 32'(o_wm[i]), 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;
        idle_in();

        // Directed vectors: r0 a0 r1 we a1 wd wm eg0 eg1 ck cport cdat
        tbl.push_back(mk(1, 12'h010, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 1, 1, 12'h020, 32'hA5A5A5A5, 4'hF,
                         0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h020, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5A5A5A5));
        tbl.push_back(mk(0, 0, 1, 1, 12'h030, 32'h11223344, 4'b0101,
                         0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h030, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFF22FF44));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 12'h010, 1, 0, 12'h020, 0, 0,
                             1, 0, 0, 0, 0));
            tbl.push_back(mk(1, 12'h010, 1, 0, 12'h020, 0, 0,
                             0, 1, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5A5A5A5));

        foreach (tbl[k]) begin
            p0_req   = tbl[k].r0;
            p0_addr  = tbl[k].a0;
            p1_req   = tbl[k].r1;
            p1_we    = tbl[k].we;
            p1_addr  = tbl[k].a1;
            p1_wdata = tbl[k].wd;
            p1_wmask = tbl[k].wm;
            cycle(w);
            for (int i = 0; i < 2; i++) begin
                chkb("vec_g0", i, s_g0[i], tbl[k].eg0);
                chkb("vec_g1", i, s_g1[i], tbl[k].eg1);
                if (tbl[k].ck) begin
                    if (tbl[k].cport)
                        chkw("vec_p1_data", i, last_p1[i], tbl[k].cdat);
                    else
                        chkw("vec_p0_data", i, last_p0[i], tbl[k].cdat);
                end
            end
        end
        idle_in();

        // Fairness: pointer aims at port 1, port 0 must win soon
        p0_req = 1'b1;
        p0_addr = 12'h011;
        cycle(w);
        for (int i = 0; i < 2; i++) gotk[i] = 0;
        p0_addr = 12'h012;
        for (int k = 1; k <= 3; k++) begin
            p0_req = (gotk[0] == 0) || (gotk[1] == 0);
            p1_req = 1'b1;
            p1_we = 1'b0;
            p1_addr = 12'h013;
            cycle(w);
            for (int i = 0; i < 2; i++)
                if (s_g0[i] && gotk[i] == 0) gotk[i] = k;
        end
        for (int i = 0; i < 2; i++)
            chkb("starve_p0_won", i, gotk[i] != 0, 1'b1);
        idle_in();
        for (int k = 0; k < 4; k++) cycle(w);

        // Randomized traffic, requesters hold until granted
        pend0 = 0;
        pend1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1;
                p0_addr = 12'h010 + 12'($urandom_range(0, 7));
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1;
                p1_we = 1'($urandom_range(0, 1));
                p1_addr = 12'h010 + 12'($urandom_range(0, 7));
                p1_wdata = $urandom;
                p1_wmask = 4'($urandom_range(0, 15));
            end
            p0_req = pend0;
            p1_req = pend1;
            cycle(w);
            if (w == 0) pend0 = 0;
            if (w == 1) pend1 = 0;
        end

        // Asynchronous reset mid-cycle with reads in flight
        p0_req = 1'b1;
        p1_req = 1'b1;
        p1_we = 1'b0;
        cycle(w);
        cycle(w);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chkb("arst_g0", i, o_g0[i], 1'b0);
            chkb("arst_g1", i, o_g1[i], 1'b0);
            chkb("arst_csb", i, o_csb[i], 1'b1);
            chkb("arst_web", i, o_web[i], 1'b1);
            chkb("arst_v0", i, o_v0[i], 1'b0);
            chkb("arst_v1", i, o_v1[i], 1'b0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_in();
        for (int k = 0; k < 5; k++) cycle(w);
        p0_req = 1'b1;
        p1_req = 1'b1;
        p0_addr = 12'h014;
        p1_addr = 12'h015;
        cycle(w);
        idle_in();
        for (int k = 0; k < 4; k++) cycle(w);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
